io_request_arbiter: RTL and testbench
=====================================

Name: io_request_arbiter

Overview:
- Arbitrates non-cacheable I/O requests from NUM_CORES cores onto one shared I/O bus.
- Returns each completion as a single broadcast response tagged with the originating core and thread.
- Sits at processor top level, between the cores' I/O request ports and the external I/O read/write signals.
- Grants are round-robin; the arbiter is fully pipelined and can issue one request per cycle.

Parameters:
- NUM_CORES, 4, number of requesting cores (1..16).
- THREADS_PER_CORE, 4, hardware threads per core; TIDW = max(1, clog2(THREADS_PER_CORE)).
- CIDW, derived max(1, clog2(NUM_CORES)), core-id width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_request_valid  in  NUM_CORES  core i has a pending request.
- io_request_store  in  NUM_CORES  1 = write, 0 = read.
- io_request_thread_idx  in  NUM_CORES*TIDW  requesting thread; slice i at [i*TIDW +: TIDW].
- io_request_address  in  NUM_CORES*32  byte address; slice i at [i*32 +: 32].
- io_request_value  in  NUM_CORES*32  write data; slice i at [i*32 +: 32].
- ia_ready  out  NUM_CORES  one-hot grant; the request of core i is consumed in a cycle where valid[i] and ready[i] are both high.
- ia_response_valid  out  1  completion valid.
- ia_response_core  out  CIDW  core that issued the completed request.
- ia_response_thread_idx  out  TIDW  thread that issued the completed request.
- ia_response_read_value  out  32  read data; undefined for writes.
- io_write_en  out  1  bus write strobe.
- io_read_en  out  1  bus read strobe.
- io_address  out  32  bus address.
- io_write_data  out  32  bus write data.
- io_read_data  in  32  bus read data, valid the cycle after io_read_en.

Behaviour:
Arbitration and grant (combinational):
- Round-robin priority starts at the core after the last granted core, wrapping modulo NUM_CORES.
- ia_ready is one-hot, and asserted only for a core whose valid is high. All zero when no core requests.
- Cores hold valid and payload stable until granted; the arbiter never drops a request.
- The last-granted pointer updates on each clock edge where any grant occurred; otherwise it holds.
- Reset sets the pointer to NUM_CORES-1, so core 0 has highest priority first.

Bus drive (combinational, same cycle as grant):
- io_write_en = grant & store; io_read_en = grant & ~store. They are mutually exclusive and never both high.
- io_address and io_write_data come from the granted core; both are 0 when there is no grant.

Pipeline:
- Cycle T: grant. Clock edge ending T registers valid, granted core id and thread_idx into stage 1.
- Cycle T+1: io_read_data presented by the device. Clock edge ending T+1 captures stage 1 plus io_read_data into the response registers.
- Cycle T+2: ia_response_valid = 1 for exactly one cycle with the core, thread_idx and read_value. Writes also produce a response.
- Back-to-back grants on consecutive cycles produce back-to-back responses in grant order. No stalls and no backpressure on responses.

Reset:
- All response outputs and stage-1 registers go to 0 immediately on reset assertion.
- In-flight requests are discarded; no response is issued for them after reset deasserts.

Edge cases:
- NUM_CORES = 1: pointer is trivial; ia_ready[0] = io_request_valid[0].
- A request whose valid drops before grant is never issued.

Test Plan:
- Single read: core 2, thread 1, addr 0x20, valid one cycle, device returns 0xDEADBEEF on the following cycle -> ia_ready[2] and io_read_en high at T with io_address = 0x20; at T+2 response valid, core = 2, thread = 1, read_value = 0xDEADBEEF.
- Single write: core 0 stores 0x1234 to 0x60 -> io_write_en high, io_read_en low, io_write_data = 0x1234 at T; response valid at T+2 with core 0.
- Contention: all 4 cores hold valid from reset -> grants in order 0, 1, 2, 3, 0 on consecutive cycles; responses follow 2 cycles later in the same order, one per cycle.
- Fairness: cores 1 and 3 continuously valid, last grant was 1 -> next grant is 3, then 1, alternating.
- Idle: no valid -> ia_ready = 0, io_read_en = io_write_en = 0, io_address = 0; no response valid.
- Reset mid-flight: grant at T, assert reset during T+1 -> ia_response_valid stays 0 and the pointer returns to core-0 priority.

Source files
------------

// File: rtl/io_request_arbiter.sv
// rtl/io_request_arbiter.sv - round-robin I/O request arbiter with broadcast completions
//
// Purpose:
//   Picks one pending non-cacheable I/O request per cycle from NUM_CORES cores
//   (round-robin), drives it onto the shared I/O bus in the same cycle, and
//   returns a tagged completion two cycles later.
//
// Ports:
//   clk                     in   clock, rising edge
//   reset                   in   asynchronous active-high reset
//   io_request_valid        in   per-core request pending
//   io_request_store        in   per-core 1 = write, 0 = read
//   io_request_thread_idx   in   per-core thread id, slice i at [i*TIDW +: TIDW]
//   io_request_address      in   per-core byte address, slice i at [i*32 +: 32]
//   io_request_value        in   per-core write data, slice i at [i*32 +: 32]
//   ia_ready                out  one-hot grant
//   ia_response_valid       out  completion valid (one cycle)
//   ia_response_core        out  completing core id
//   ia_response_thread_idx  out  completing thread id
//   ia_response_read_value  out  read data (don't-care for writes)
//   io_write_en             out  bus write strobe
//   io_read_en              out  bus read strobe
//   io_address              out  bus address (0 when idle)
//   io_write_data           out  bus write data (0 when idle)
//   io_read_data            in   bus read data, valid the cycle after io_read_en

module io_request_arbiter #(
  parameter int NUM_CORES        = 4,
  parameter int THREADS_PER_CORE = 4,
  localparam int TIDW = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1,
  localparam int CIDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      io_request_valid,
  input  logic [NUM_CORES-1:0]      io_request_store,
  input  logic [NUM_CORES*TIDW-1:0] io_request_thread_idx,
  input  logic [NUM_CORES*32-1:0]   io_request_address,
  input  logic [NUM_CORES*32-1:0]   io_request_value,
  output logic [NUM_CORES-1:0]      ia_ready,
  output logic                      ia_response_valid,
  output logic [CIDW-1:0]           ia_response_core,
  output logic [TIDW-1:0]           ia_response_thread_idx,
  output logic [31:0]               ia_response_read_value,
  output logic                      io_write_en,
  output logic                      io_read_en,
  output logic [31:0]               io_address,
  output logic [31:0]               io_write_data,
  input  logic [31:0]               io_read_data
);

  logic [CIDW-1:0]      r_last_grant;
  logic [NUM_CORES-1:0] w_grant;
  logic [CIDW-1:0]      w_grant_id;
  logic                 w_any;
  int                   w_scan_idx;

  logic                 r_s1_valid;
  logic [CIDW-1:0]      r_s1_core;
  logic [TIDW-1:0]      r_s1_thread;

  logic                 r_rsp_valid;
  logic [CIDW-1:0]      r_rsp_core;
  logic [TIDW-1:0]      r_rsp_thread;
  logic [31:0]          r_rsp_data;

  logic                 w_sel_store;
  logic [31:0]          w_sel_addr;
  logic [31:0]          w_sel_value;
  logic [TIDW-1:0]      w_sel_thread;

  // Scan starting one past the last winner; the first valid core found wins.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_any      = 1'b0;
    w_scan_idx = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_scan_idx = (int'(r_last_grant) + k) % NUM_CORES;
      if (!w_any && io_request_valid[w_scan_idx]) begin
        w_grant[w_scan_idx] = 1'b1;
        w_grant_id          = CIDW'(w_scan_idx);
        w_any               = 1'b1;
      end
    end
  end

  assign w_sel_store  = io_request_store[w_grant_id];
  assign w_sel_addr   = io_request_address[int'(w_grant_id) * 32 +: 32];
  assign w_sel_value  = io_request_value[int'(w_grant_id) * 32 +: 32];
  assign w_sel_thread = io_request_thread_idx[int'(w_grant_id) * TIDW +: TIDW];

  assign ia_ready      = w_grant;
  assign io_write_en   = w_any & w_sel_store;
  assign io_read_en    = w_any & ~w_sel_store;
  assign io_address    = w_any ? w_sel_addr  : 32'd0;
  assign io_write_data = w_any ? w_sel_value : 32'd0;

  // Pointer resets to the last core so core 0 is first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= CIDW'(NUM_CORES - 1);
    end else if (w_any) begin
      r_last_grant <= w_grant_id;
    end
  end

  // Two-stage completion pipeline; read data is sampled as stage 1 advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_core    <= '0;
      r_s1_thread  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_core   <= '0;
      r_rsp_thread <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_s1_valid   <= w_any;
      r_s1_core    <= w_grant_id;
      r_s1_thread  <= w_sel_thread;
      r_rsp_valid  <= r_s1_valid;
      r_rsp_core   <= r_s1_core;
      r_rsp_thread <= r_s1_thread;
      r_rsp_data   <= io_read_data;
    end
  end

  assign ia_response_valid      = r_rsp_valid;
  assign ia_response_core       = r_rsp_core;
  assign ia_response_thread_idx = r_rsp_thread;
  assign ia_response_read_value = r_rsp_data;

endmodule

// File: tb/tb_io_request_arbiter.sv
// tb/tb_io_request_arbiter.sv - self-checking bench for io_request_arbiter

module tb_io_request_arbiter;

  localparam int NC = 4;
  localparam int TW = 2;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    io_request_valid;
  logic [NC-1:0]    io_request_store;
  logic [NC*TW-1:0] io_request_thread_idx;
  logic [NC*32-1:0] io_request_address;
  logic [NC*32-1:0] io_request_value;
  logic [NC-1:0]    ia_ready;
  logic             ia_response_valid;
  logic [CW-1:0]    ia_response_core;
  logic [TW-1:0]    ia_response_thread_idx;
  logic [31:0]      ia_response_read_value;
  logic             io_write_en;
  logic             io_read_en;
  logic [31:0]      io_address;
  logic [31:0]      io_write_data;
  logic [31:0]      io_read_data;

  io_request_arbiter #(.NUM_CORES(NC), .THREADS_PER_CORE(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_request_valid       (io_request_valid),
    .io_request_store       (io_request_store),
    .io_request_thread_idx  (io_request_thread_idx),
    .io_request_address     (io_request_address),
    .io_request_value       (io_request_value),
    .ia_ready               (ia_ready),
    .ia_response_valid      (ia_response_valid),
    .ia_response_core       (ia_response_core),
    .ia_response_thread_idx (ia_response_thread_idx),
    .ia_response_read_value (ia_response_read_value),
    .io_write_en            (io_write_en),
    .io_read_en             (io_read_en),
    .io_address             (io_address),
    .io_write_data          (io_write_data),
    .io_read_data           (io_read_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic set_core(input int i, input bit v, input bit st, input int thr,
                          input logic [31:0] a, input logic [31:0] d);
    io_request_valid[i]            = v;
    io_request_store[i]            = st;
    io_request_thread_idx[i*TW +: TW] = TW'(thr);
    io_request_address[i*32 +: 32] = a;
    io_request_value[i*32 +: 32]   = d;
  endtask

  task automatic clear_inputs();
    io_request_valid      = '0;
    io_request_store      = '0;
    io_request_thread_idx = '0;
    io_request_address    = '0;
    io_request_value      = '0;
    io_read_data          = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    chk("rst_rsp_valid", {31'b0, ia_response_valid}, 32'd0);
    chk("rst_ready", {28'b0, ia_ready}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  store;
    logic [3:0]  exp_ready;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl[9];

  // Reference model storage for the random phase, indexed by cycle number.
  bit          ev   [0:1023];
  int          ecore[0:1023];
  int          ethr [0:1023];
  bit          erd  [0:1023];
  logic [31:0] edat [0:1023];
  bit          pend [NC];

  initial begin
    int last;
    int g;
    int idx;
    int thr_sel;
    logic [31:0] a_sel;
    logic [31:0] d_sel;
    bit st_sel;

    // Each core i carries addr 0x1000+16*i, data 0xA000+i, thread i.
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,    32'h0};
    tbl[1] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1000, 32'hA000};
    tbl[2] = '{4'b1111, 4'b0010, 4'b0010, 1'b0, 1'b1, 32'h1010, 32'hA001};
    tbl[3] = '{4'b1010, 4'b0000, 4'b1000, 1'b1, 1'b0, 32'h1030, 32'hA003};
    tbl[4] = '{4'b1010, 4'b1010, 4'b0010, 1'b0, 1'b1, 32'h1010, 32'hA001};
    tbl[5] = '{4'b0101, 4'b0100, 4'b0100, 1'b0, 1'b1, 32'h1020, 32'hA002};
    tbl[6] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1000, 32'hA000};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,    32'h0};
    tbl[8] = '{4'b1001, 4'b0001, 4'b1000, 1'b1, 1'b0, 32'h1030, 32'hA003};

    clear_inputs();
    reset = 1'b1;
    #1;
    chk("rst_async_rsp", {31'b0, ia_response_valid}, 32'd0);
    do_reset();

    // Table vectors: one row per cycle, pointer history carries across rows.
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < NC; i++)
        set_core(i, tbl[r].valid[i], tbl[r].store[i], i, 32'h1000 + 32'(16 * i), 32'hA000 + 32'(i));
      #1;
      chk($sformatf("tbl%0d_ready", r), {28'b0, ia_ready}, {28'b0, tbl[r].exp_ready});
      chk($sformatf("tbl%0d_ren", r), {31'b0, io_read_en}, {31'b0, tbl[r].exp_ren});
      chk($sformatf("tbl%0d_wen", r), {31'b0, io_write_en}, {31'b0, tbl[r].exp_wen});
      chk($sformatf("tbl%0d_addr", r), io_address, tbl[r].exp_addr);
      chk($sformatf("tbl%0d_wdata", r), io_write_data, tbl[r].exp_wdata);
      tick();
    end

    // Single read: core 2 thread 1 addr 0x20, device answers 0xDEADBEEF.
    do_reset();
    set_core(2, 1'b1, 1'b0, 1, 32'h20, 32'h0);
    #1;
    chk("rd_ready", {28'b0, ia_ready}, 32'b0100);
    chk("rd_ren", {31'b0, io_read_en}, 32'd1);
    chk("rd_wen", {31'b0, io_write_en}, 32'd0);
    chk("rd_addr", io_address, 32'h20);
    tick();
    clear_inputs();
    io_read_data = 32'hDEADBEEF;
    #1;
    chk("rd_t1_valid", {31'b0, ia_response_valid}, 32'd0);
    tick();
    io_read_data = 32'h0;
    chk("rd_t2_valid", {31'b0, ia_response_valid}, 32'd1);
    chk("rd_t2_core", {30'b0, ia_response_core}, 32'd2);
    chk("rd_t2_thread", {30'b0, ia_response_thread_idx}, 32'd1);
    chk("rd_t2_data", ia_response_read_value, 32'hDEADBEEF);
    tick();
    chk("rd_t3_valid", {31'b0, ia_response_valid}, 32'd0);

    // Single write: core 0 stores 0x1234 to 0x60.
    set_core(0, 1'b1, 1'b1, 3, 32'h60, 32'h1234);
    #1;
    chk("wr_ready", {28'b0, ia_ready}, 32'b0001);
    chk("wr_wen", {31'b0, io_write_en}, 32'd1);
    chk("wr_ren", {31'b0, io_read_en}, 32'd0);
    chk("wr_addr", io_address, 32'h60);
    chk("wr_wdata", io_write_data, 32'h1234);
    tick();
    clear_inputs();
    tick();
    chk("wr_t2_valid", {31'b0, ia_response_valid}, 32'd1);
    chk("wr_t2_core", {30'b0, ia_response_core}, 32'd0);
    chk("wr_t2_thread", {30'b0, ia_response_thread_idx}, 32'd3);

    // Idle: nothing on the bus, no response.
    tick();
    #1;
    chk("idle_ready", {28'b0, ia_ready}, 32'd0);
    chk("idle_ren", {31'b0, io_read_en}, 32'd0);
    chk("idle_wen", {31'b0, io_write_en}, 32'd0);
    chk("idle_addr", io_address, 32'd0);
    chk("idle_rsp", {31'b0, ia_response_valid}, 32'd0);

    // Contention: all cores valid from reset -> 0,1,2,3,0, responses 2 cycles later.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k >= 2 && k < 7) begin
        chk($sformatf("cont%0d_rsp_valid", k), {31'b0, ia_response_valid}, 32'd1);
        chk($sformatf("cont%0d_rsp_core", k), {30'b0, ia_response_core}, 32'((k - 2) % NC));
        chk($sformatf("cont%0d_rsp_thr", k), {30'b0, ia_response_thread_idx}, 32'((k - 2) % NC));
      end else begin
        chk($sformatf("cont%0d_rsp_valid", k), {31'b0, ia_response_valid}, 32'd0);
      end
      for (int i = 0; i < NC; i++)
        set_core(i, k < 5, 1'b0, i, 32'h100 + 32'(i), 32'h0);
      #1;
      chk($sformatf("cont%0d_ready", k), {28'b0, ia_ready}, (k < 5) ? 32'(1 << (k % NC)) : 32'd0);
      tick();
    end

    // Fairness: cores 1 and 3 always valid -> 1,3,1,3...
    do_reset();
    set_core(1, 1'b1, 1'b0, 0, 32'h4, 32'h0);
    set_core(3, 1'b1, 1'b0, 0, 32'h8, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("fair%0d_ready", k), {28'b0, ia_ready}, (k % 2 == 0) ? 32'b0010 : 32'b1000);
      tick();
    end

    // Reset mid-flight: grant core 1 at T, reset during T+1.
    do_reset();
    clear_inputs();
    set_core(0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
    #1;
    tick();
    clear_inputs();
    set_core(1, 1'b1, 1'b0, 2, 32'h44, 32'h0);
    #1;
    chk("mid_grant", {28'b0, ia_ready}, 32'b0010);
    tick();
    clear_inputs();
    io_read_data = 32'h5555AAAA;
    reset = 1'b1;
    #1;
    chk("mid_async_rsp", {31'b0, ia_response_valid}, 32'd0);
    tick();
    chk("mid_t2_rsp", {31'b0, ia_response_valid}, 32'd0);
    reset = 1'b0;
    io_request_valid = 4'b1111;
    #1;
    chk("mid_ptr_ready", {28'b0, ia_ready}, 32'b0001);
    tick();
    clear_inputs();
    chk("mid_t3_rsp", {31'b0, ia_response_valid}, 32'd0);
    tick();

    // Random phase against a behavioural model.
    do_reset();
    last = NC - 1;
    for (int i = 0; i < NC; i++) pend[i] = 1'b0;
    for (int c = 0; c < 1024; c++) begin
      ev[c] = 1'b0; ecore[c] = 0; ethr[c] = 0; erd[c] = 1'b0; edat[c] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      if (ev[c]) begin
        chk("rand_rsp_valid", {31'b0, ia_response_valid}, 32'd1);
        chk("rand_rsp_core", {30'b0, ia_response_core}, 32'(ecore[c]));
        chk("rand_rsp_thr", {30'b0, ia_response_thread_idx}, 32'(ethr[c]));
        if (erd[c]) chk("rand_rsp_data", ia_response_read_value, edat[c]);
      end else begin
        chk("rand_rsp_valid", {31'b0, ia_response_valid}, 32'd0);
      end

      io_read_data = $urandom;
      edat[c + 1] = io_read_data;

      for (int i = 0; i < NC; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 9) == 0) begin
            pend[i] = 1'b0;
            io_request_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_core(i, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, $urandom);
        end else begin
          io_request_valid[i] = 1'b0;
        end
      end
      #1;

      g = -1;
      for (int j = 1; j <= NC; j++) begin
        idx = (last + j) % NC;
        if (g < 0 && io_request_valid[idx]) g = idx;
      end

      if (g < 0) begin
        chk("rand_ready", {28'b0, ia_ready}, 32'd0);
        chk("rand_ren", {31'b0, io_read_en}, 32'd0);
        chk("rand_wen", {31'b0, io_write_en}, 32'd0);
        chk("rand_addr", io_address, 32'd0);
        chk("rand_wdata", io_write_data, 32'd0);
      end else begin
        st_sel  = io_request_store[g];
        a_sel   = io_request_address[g*32 +: 32];
        d_sel   = io_request_value[g*32 +: 32];
        thr_sel = int'(io_request_thread_idx[g*TW +: TW]);
        chk("rand_ready", {28'b0, ia_ready}, 32'(1 << g));
        chk("rand_ren", {31'b0, io_read_en}, {31'b0, ~st_sel});
        chk("rand_wen", {31'b0, io_write_en}, {31'b0, st_sel});
        chk("rand_addr", io_address, a_sel);
        chk("rand_wdata", io_write_data, d_sel);
        ev[c + 2]    = 1'b1;
        ecore[c + 2] = g;
        ethr[c + 2]  = thr_sel;
        erd[c + 2]   = ~st_sel;
        last         = g;
        pend[g]      = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
